// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the cascaded PLL reset/lock sequencer.
// State encoding is visible on state_o for debug.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST0  = 3'd0,
    WAIT0 = 3'd1,
    RST1  = 3'd2,
    WAIT1 = 3'd3,
    RUN   = 3'd4,
    LOSS0 = 3'd5,
    RETRY = 3'd6,
    FAULT = 3'd7
  } pll_state_e;

  localparam int LOSS_FILTER_LEN = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Clears to 0 so a lock is never seen during reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async level through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_sequencer.sv
// Reset/lock sequencer for two cascaded PLLs (PLL0 feeds PLL1).
// Optional macro PLLSEQ_LOSS_FILTER_EN debounces lock loss over 4 cycles.
module pll_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 4800,
  parameter int LOCK_TIMEOUT_CYCLES = 48000,
  parameter int PLL_RST_CYCLES      = 48,
  parameter int MAX_RETRIES         = 3
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic locked0_i,
  input  logic locked1_i,
  input  logic restart_i,
  output logic pll0_rst_o,
  output logic pll1_rst_o,
  output logic dom0_rst_n_o,
  output logic dom1_rst_n_o,
  output logic fault_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  import pll_seq_pkg::*;

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(
    max2(LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES) + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  pll_state_e st, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stab;
  logic [RW-1:0] retry;
  logic lk0, lk1, lk_sel;
  logic loss0, loss1;
  logic rst_done, tmo, stb_hit, enter;
  logic pll0_d, pll1_d, dom0_d, dom1_d, fault_d;

  sync_2ff u_sync0 (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked0_i),
    .q     (lk0)
  );

  sync_2ff u_sync1 (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked1_i),
    .q     (lk1)
  );

`ifdef PLLSEQ_LOSS_FILTER_EN
  localparam int LW = $clog2(LOSS_FILTER_LEN + 1);
  localparam logic [LW-1:0] LOW_LAST = LW'(LOSS_FILTER_LEN - 1);

  logic [LW-1:0] low0, low1;

  // count consecutive synced-low cycles, saturating at the filter length
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      low0 <= '0;
      low1 <= '0;
    end else begin
      if (lk0) low0 <= '0;
      else if (low0 != LOW_LAST) low0 <= low0 + 1'b1;
      if (lk1) low1 <= '0;
      else if (low1 != LOW_LAST) low1 <= low1 + 1'b1;
    end
  end

  assign loss0 = ~lk0 & (low0 == LOW_LAST);
  assign loss1 = ~lk1 & (low1 == LOW_LAST);
`else
  assign loss0 = ~lk0;
  assign loss1 = ~lk1;
`endif

  assign lk_sel   = (st == WAIT1) ? lk1 : lk0;
  assign rst_done = (cnt == RST_LAST);
  assign tmo      = (cnt == TMO_LAST);
  assign stb_hit  = lk_sel & (stab == STB_LAST);
  assign enter    = restart_i | (nxt != st);

  // state, shared cycle counter, stable counter and retry count
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      st    <= RST0;
      cnt   <= '0;
      stab  <= '0;
      retry <= '0;
    end else begin
      st <= nxt;
      if (enter) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      if (enter) stab <= '0;
      else if (st == WAIT0 || st == WAIT1)
        stab <= lk_sel ? stab + 1'b1 : '0;
      if (restart_i) retry <= '0;
      else if (nxt == RUN) retry <= '0;
      else if (nxt == RETRY) retry <= retry + 1'b1;
    end
  end

  // next state; restart beats everything, loss beats timeout
  always_comb begin
    nxt = st;
    if (restart_i) begin
      nxt = RST0;
    end else begin
      unique case (st)
        RST0:
          if (rst_done) nxt = WAIT0;
        WAIT0:
          if (stb_hit) nxt = RST1;
          else if (tmo) nxt = RETRY;
        RST1:
          if (rst_done) nxt = WAIT1;
        WAIT1:
          if (loss0) nxt = LOSS0;
          else if (stb_hit) nxt = RUN;
          else if (tmo) nxt = RETRY;
        RUN:
          if (loss0) nxt = LOSS0;
          else if (loss1) nxt = RST1;
        LOSS0:
          nxt = RST0;
        RETRY:
          nxt = (retry == RTY_MAX) ? FAULT : RST0;
        FAULT:
          nxt = FAULT;
        default:
          nxt = RST0;
      endcase
    end
  end

  // reset pattern implied by the state being entered
  always_comb begin
    pll0_d  = 1'b1;
    pll1_d  = 1'b1;
    dom0_d  = 1'b0;
    dom1_d  = 1'b0;
    fault_d = 1'b0;
    unique case (nxt)
      WAIT0: pll0_d = 1'b0;
      RST1: begin
        pll0_d = 1'b0;
        dom0_d = 1'b1;
      end
      WAIT1: begin
        pll0_d = 1'b0;
        pll1_d = 1'b0;
        dom0_d = 1'b1;
      end
      RUN: begin
        pll0_d = 1'b0;
        pll1_d = 1'b0;
        dom0_d = 1'b1;
        dom1_d = 1'b1;
      end
      FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  // register the reset outputs so they are glitch-free
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll0_rst_o   <= 1'b1;
      pll1_rst_o   <= 1'b1;
      dom0_rst_n_o <= 1'b0;
      dom1_rst_n_o <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      pll0_rst_o   <= pll0_d;
      pll1_rst_o   <= pll1_d;
      dom0_rst_n_o <= dom0_d;
      dom1_rst_n_o <= dom1_d;
      fault_o      <= fault_d;
    end
  end

  assign retry_cnt_o = retry;
  assign state_o     = st;

endmodule

// File: tb/tb_pll_sequencer.sv
// Bench for pll_sequencer: PLL lock emulation, reference model,
// per-cycle compare plus directed literal checks.
module tb_pll_sequencer;

  localparam int S = 8;
  localparam int T = 20;
  localparam int R = 4;
  localparam int M = 2;
  localparam int RW = $clog2(M + 1);
`ifdef PLLSEQ_LOSS_FILTER_EN
  localparam int LOSS_N = 4;
`else
  localparam int LOSS_N = 1;
`endif
  localparam int LAT = 2 + LOSS_N;

  localparam int P_RST0  = 0;
  localparam int P_WAIT0 = 1;
  localparam int P_RST1  = 2;
  localparam int P_WAIT1 = 3;
  localparam int P_RUN   = 4;
  localparam int P_LOSS0 = 5;
  localparam int P_RETRY = 6;
  localparam int P_FAULT = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  logic nat0 = 1'b0, nat1 = 1'b0;
  logic kill0 = 1'b0, kill1 = 1'b0;
  logic locked0, locked1;
  logic pll0_rst, pll1_rst, dom0_n, dom1_n, fault;
  logic [RW-1:0] retry_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0 = 0, c1 = 0;
  bit chk_on = 1'b0;

  assign locked0 = nat0 & ~kill0;
  assign locked1 = nat1 & ~kill1;

  always #5 clk = ~clk;

  pll_sequencer #(
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .PLL_RST_CYCLES      (R),
    .MAX_RETRIES         (M)
  ) dut (
    .clkin        (clk),
    .rst_n        (rst_n),
    .locked0_i    (locked0),
    .locked1_i    (locked1),
    .restart_i    (restart),
    .pll0_rst_o   (pll0_rst),
    .pll1_rst_o   (pll1_rst),
    .dom0_rst_n_o (dom0_n),
    .dom1_rst_n_o (dom1_n),
    .fault_o      (fault),
    .retry_cnt_o  (retry_cnt),
    .state_o      (state)
  );

  // PLL emulation: lock rises 5 cycles after RST falls
  always @(negedge clk) begin
    if (pll0_rst) c0 = 0;
    else if (c0 < 5) c0++;
    nat0 = (c0 >= 5);
    if (pll1_rst) c1 = 0;
    else if (c1 < 5) c1++;
    nat1 = (c1 >= 5);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // ---------------- reference model ----------------
  int ph, age, rty;
  int q0[$], q1[$], g0[$], g1[$], hist[$];

  function automatic int trail(input int qq[$], input int v);
    int n;
    n = 0;
    for (int i = qq.size() - 1; i >= 0; i--) begin
      if (qq[i] != v) break;
      n++;
    end
    return n;
  endfunction

  function automatic void mreset();
    ph = P_RST0;
    age = 0;
    rty = 0;
    q0 = '{0, 0};
    q1 = '{0, 0};
    g0.delete();
    g1.delete();
    hist.delete();
  endfunction

  function automatic void mstep();
    int lk0, lk1, nx;
    bit l0, l1;
    lk0 = q0[1];
    lk1 = q1[1];
    q0.push_front(int'(locked0));
    void'(q0.pop_back());
    q1.push_front(int'(locked1));
    void'(q1.pop_back());
    g0.push_back(lk0);
    g1.push_back(lk1);
    if (g0.size() > 8) void'(g0.pop_front());
    if (g1.size() > 8) void'(g1.pop_front());
    l0 = trail(g0, 0) >= LOSS_N;
    l1 = trail(g1, 0) >= LOSS_N;
    nx = ph;
    if (restart) begin
      nx = P_RST0;
      rty = 0;
    end else begin
      case (ph)
        P_RST0: if (age == R - 1) nx = P_WAIT0;
        P_WAIT0: begin
          hist.push_back(lk0);
          if (trail(hist, 1) >= S) nx = P_RST1;
          else if (age == T - 1) begin
            nx = P_RETRY;
            rty++;
          end
        end
        P_RST1: if (age == R - 1) nx = P_WAIT1;
        P_WAIT1: begin
          if (l0) nx = P_LOSS0;
          else begin
            hist.push_back(lk1);
            if (trail(hist, 1) >= S) nx = P_RUN;
            else if (age == T - 1) begin
              nx = P_RETRY;
              rty++;
            end
          end
        end
        P_RUN: begin
          if (l0) nx = P_LOSS0;
          else if (l1) nx = P_RST1;
        end
        P_LOSS0: nx = P_RST0;
        P_RETRY: nx = (rty == M) ? P_FAULT : P_RST0;
        default: nx = ph;
      endcase
    end
    if (nx == P_RUN) rty = 0;
    if (restart || nx != ph) begin
      age = 0;
      hist.delete();
    end else begin
      age++;
    end
    ph = nx;
  endfunction

  // {pll0_rst, pll1_rst, dom0_rst_n, dom1_rst_n, fault}
  function automatic logic [4:0] outs_for(input int p);
    logic hold0, up0, up1;
    hold0 = (p == P_RST0) || (p == P_LOSS0) ||
            (p == P_RETRY) || (p == P_FAULT);
    up0 = (p == P_RST1) || (p == P_WAIT1) || (p == P_RUN);
    up1 = (p == P_WAIT1) || (p == P_RUN);
    return {hold0, ~up1, up0, p == P_RUN, p == P_FAULT};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else mstep();
  end

  // compare DUT against model every cycle
  always begin
    logic [9:0] act, exp_v;
    @(negedge clk);
    #1;
    if (chk_on) begin
      act = {pll0_rst, pll1_rst, dom0_n, dom1_n, fault,
             state, retry_cnt};
      exp_v = {outs_for(ph), 3'(ph), RW'(rty)};
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL model cyc=%0d got=%b want=%b (rst0 rst1 d0n d1n flt st rty)",
                 cyc, act, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic int sig(input int w);
    case (w)
      0: return int'(pll0_rst);
      1: return int'(pll1_rst);
      2: return int'(dom0_n);
      3: return int'(dom1_n);
      4: return int'(fault);
      default: return int'(state);
    endcase
  endfunction

  task automatic wait_until(input int w, input int v, input int bound,
                            input string nm, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sig(w) == v) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout got none want %0d", nm, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    kill0 = 1'b0;
    kill1 = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    chk("rst_pll0", pll0_rst, 1);
    chk("rst_pll1", pll1_rst, 1);
    chk("rst_dom", {dom0_n, dom1_n, fault}, 0);
    chk("rst_state", state, P_RST0);
    chk("rst_retry", retry_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
  endtask

  initial begin
    int at, lat;
    int kt0, kt1;

    do_reset();
    wait_until(2, 1, 100, "dom0_up", at);
    chk("dom0_up_cycle", at, 18);
    wait_until(3, 1, 100, "dom1_up", at);
    chk("dom1_up_cycle", at, 36);
    chk("run_state", state, P_RUN);
    chk("run_retry", retry_cnt, 0);

    // PLL1 lock loss in RUN
    kill1 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!dom1_n) begin
        lat = i;
        break;
      end
    end
    chk("loss1_latency", lat, LAT);
    chk("loss1_dom0_kept", dom0_n, 1);
    chk("loss1_state", state, P_RST1);
    repeat (10 - lat) @(negedge clk);
    kill1 = 1'b0;
    wait_until(5, P_RUN, 200, "relock1", at);

    // PLL0 lock loss in RUN
    kill0 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pll0_rst && pll1_rst && !dom0_n && !dom1_n) begin
        lat = i;
        break;
      end
    end
    chk("loss0_latency", lat, LAT);
    chk("loss0_state", state, P_LOSS0);
    repeat (6 - lat) @(negedge clk);
    kill0 = 1'b0;
    wait_until(5, P_RUN, 200, "relock0", at);

`ifdef PLLSEQ_LOSS_FILTER_EN
    kill0 = 1'b1;
    repeat (3) @(negedge clk);
    kill0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("filter_short_state", state, P_RUN);
    chk("filter_short_dom0", dom0_n, 1);
    kill0 = 1'b1;
    repeat (4) @(negedge clk);
    kill0 = 1'b0;
    wait_until(5, P_LOSS0, 10, "filter_long", at);
    wait_until(5, P_RUN, 200, "relock_f", at);
`endif

    // single-cycle lk0 glitch during WAIT0
    do_reset();
    for (int i = 0; i < 40 && cyc != 10; i++) @(negedge clk);
    kill0 = 1'b1;
    @(negedge clk);
    kill0 = 1'b0;
    wait_until(2, 1, 100, "glitch_dom0", at);
    chk("glitch_dom0_cycle", at, 21);
    wait_until(5, P_RUN, 200, "glitch_run", at);

    // PLL1 never locks: retries then FAULT
    kill1 = 1'b1;
    wait_until(4, 1, 400, "fault_up", at);
    chk("fault_state", state, P_FAULT);
    chk("fault_retry", retry_cnt, M);
    chk("fault_resets", {pll0_rst, pll1_rst, dom0_n, dom1_n}, 4'b1100);
    repeat (5) @(negedge clk);
    chk("fault_sticky", fault, 1);
    restart = 1'b1;
    kill1 = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_state", state, P_RST0);
    chk("restart_fault", fault, 0);
    chk("restart_retry", retry_cnt, 0);
    wait_until(5, P_RUN, 200, "restart_run", at);

    // randomized lock drops, restarts and resets
    kt0 = 0;
    kt1 = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      restart = ($urandom_range(0, 399) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      if (kt0 > 0) kt0--;
      else if ($urandom_range(0, 149) == 0)
        kt0 = $urandom_range(1, 8);
      if (kt1 > 0) kt1--;
      else if ($urandom_range(0, 119) == 0)
        kt1 = ($urandom_range(0, 3) == 0) ?
              $urandom_range(20, 60) : $urandom_range(1, 8);
      kill0 = (kt0 > 0);
      kill1 = (kt1 > 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    restart = 1'b0;
    kill0 = 1'b0;
    kill1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
# pll_sequencer

Reset and lock sequencer for the board's two cascaded ECP5 PLLs: PLL0 (48 MHz in → 100/50 MHz) feeds PLL1 (100 MHz in → 125/25 MHz). It runs on the free-running 48 MHz oscillator and drives both PLL `RST` pins, which requires `PLLRST_ENA("ENABLED")` on both instances. It qualifies each `LOCK` with stability and timeout counters and releases the per-domain resets in dependency order. On lock loss or repeated lock failure it re-sequences or enters a sticky fault state.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, 4800: consecutive synced-high lock cycles required (100 µs @ 48 MHz).
- `LOCK_TIMEOUT_CYCLES`, 48000: maximum wait for a stable lock per attempt (1 ms).
- `PLL_RST_CYCLES`, 48: PLL `RST` assertion width.
- `MAX_RETRIES`, 3: failed attempts before FAULT.

Ports:
- `clkin` in 1: 48 MHz oscillator clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked0_i` in 1: PLL0 `LOCK`, asynchronous.
- `locked1_i` in 1: PLL1 `LOCK`, asynchronous.
- `restart_i` in 1: single-cycle pulse; full re-sequence from any state, including FAULT.
- `pll0_rst_o` out 1: PLL0 `RST`, active-high.
- `pll1_rst_o` out 1: PLL1 `RST`, active-high.
- `dom0_rst_n_o` out 1: reset for the 100/50 MHz domains, active-low.
- `dom1_rst_n_o` out 1: reset for the 125/25 MHz domains, active-low.
- `fault_o` out 1: sticky; high after `MAX_RETRIES` failures.
- `retry_cnt_o` out `$clog2(MAX_RETRIES+1)`: failed attempts in the current sequence.
- `state_o` out 3: current state encoding, for debug.

## Operation
- `locked0_i` and `locked1_i` each pass through a 2-FF synchronizer; the FSM uses only the synced `lk0`/`lk1`.
- RST0: assert both PLL resets and both domain resets for `PLL_RST_CYCLES`, then go to WAIT0.
- WAIT0: release `pll0_rst_o`.
  - The stable counter counts consecutive `lk0` highs and clears on any low.
  - Reaching `LOCK_STABLE_CYCLES` releases `dom0_rst_n_o` and goes to RST1.
  - Reaching `LOCK_TIMEOUT_CYCLES` first goes to RETRY.
- RST1: assert `pll1_rst_o` for `PLL_RST_CYCLES`, then go to WAIT1.
- WAIT1: the same stable/timeout rule applied to `lk1`.
  - Success releases `dom1_rst_n_o` and goes to RUN.
  - Timeout goes to RETRY.
  - If `lk0` drops during WAIT1, go to LOSS0.
- RUN: clears `retry_cnt`.
  - A loss of `lk0` goes to LOSS0.
  - A loss of `lk1` alone asserts `dom1_rst_n_o=0` and goes to RST1 (PLL0 and domain 0 stay up).
- LOSS0: assert all resets and go to RST0 on the next cycle; `retry_cnt` is unchanged.
- RETRY: increment `retry_cnt`.
  - If the new value equals `MAX_RETRIES`, go to FAULT.
  - Otherwise go to RST0 (a WAIT1 timeout also restarts from RST0).
- FAULT: all resets asserted and `fault_o=1`. Only `rst_n` or `restart_i` leave it.
- `restart_i`: in any state, on the next edge, go to RST0, clear `retry_cnt` and clear `fault_o`. It has priority over all other transitions in the same cycle.
- If lock loss and timeout happen in the same cycle, lock loss wins.
- Counters: one shared counter, width `$clog2(max(LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES)+1)`.
  - Cleared on every state entry. It saturates and does not wrap.
  - A separate stable counter runs in WAIT0 and WAIT1 only.

## Timing
- All outputs are registered and change only on `clkin` rising edges.
- Reset values: `pll0_rst_o=1`, `pll1_rst_o=1`, `dom0_rst_n_o=0`, `dom1_rst_n_o=0`, `fault_o=0`, `retry_cnt_o=0`, state RST0.
- The lock input to the FSM reaction is 3 cycles (2 sync stages + 1 state register).
- In RUN, lock loss to reset assertion is 3 cycles without the filter (see Configuration).
- Resets assert asynchronously when `rst_n` goes low. Release follows the FSM after `rst_n` deasserts.
- The domain resets are released in the `clkin` domain; each consumer domain must resynchronize its own release.
- `rst_n` low mid-sequence aborts immediately to the reset values.

## Configuration
- `PLLSEQ_LOSS_FILTER_EN` defined: in RUN and WAIT1, a lock-loss event needs 4 consecutive synced-low cycles, adding 3 cycles of latency.
- Not defined: a single synced-low cycle triggers the loss handling.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum (RST0, WAIT0, RST1, WAIT1, RUN, LOSS0, RETRY, FAULT → 0..7);
  - the `LOSS_FILTER_LEN=4` constant.
- One sub-module, `sync_2ff`, instantiated twice, for the lock synchronizers.

## Test plan
- Params 8/20/4/2. Both locks rise 5 cycles after each PLL reset releases:
  - `dom0_rst_n_o` rises 8 stable cycles after `lk0` is seen;
  - then RST1 runs;
  - `dom1_rst_n_o` rises; state RUN; `retry_cnt_o=0`.
- `locked1_i` stays 0: RETRY twice, then FAULT with `fault_o=1` and all resets asserted. A `restart_i` pulse returns to RST0 with `fault_o=0`.
- In RUN, drop `locked1_i` for 10 cycles: `dom1_rst_n_o=0` 3 cycles later, `dom0_rst_n_o` stays 1, and the sequence re-enters RST1.
- In RUN, drop `locked0_i`: all four resets assert within 4 cycles and the sequence restarts from RST0.
- `lk0` glitches low once during WAIT0: the stable counter clears and `dom0` release is delayed by the glitch position plus 8.
- With `PLLSEQ_LOSS_FILTER_EN` defined, a 3-cycle low on `locked0_i` in RUN causes no reset; a 4-cycle low triggers LOSS0.
